mul_iter_radix: RTL and testbench

//  Parametrised iterative multiplier for the RV32M unit: MUL/MULH/MULHSU/MULHU.

---
 rtl/mul_iter_radix.sv | 125 ++++++++++++
 tb/tb_mul_iter_radix.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter_radix.sv
// Iterative radix-2^DIGIT_W multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Consumes one DIGIT_W slice of B per cycle against sign/zero-extended A.
module mul_iter_radix #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DIGIT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            signed_a_i,
  input  logic            signed_b_i,
  input  logic            upper_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned NDIG  = XLEN / DIGIT_W;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q;
  logic [XLEN:0]     a_q;
  logic [XLEN-1:0]   b_q;
  logic              sb_q;
  logic              upper_q;
  logic [PW-1:0]     acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              valid_q;
  logic [XLEN-1:0]   result_q;

  logic [DIGIT_W-1:0] digit;
  logic               is_last;
  logic               d_top;
  logic [PW-1:0]      a_w;
  logic [PW-1:0]      d_w;
  logic [PW-1:0]      pp;
  logic [31:0]        shamt;
  logic [PW-1:0]      acc_nxt;

  // Both factors are extended to the full product width so a plain multiply is exact mod 2^PW.
  always_comb begin
    digit   = b_q[DIGIT_W-1:0];
    is_last = (cnt_q == CNT_W'(NDIG - 1));
    d_top   = is_last & sb_q & digit[DIGIT_W-1];
    a_w     = {{(XLEN - 1){a_q[XLEN]}}, a_q};
    d_w     = {{(PW - DIGIT_W - 1){d_top}}, d_top, digit};
    pp      = a_w * d_w;
    shamt   = 32'(cnt_q) * 32'(DIGIT_W);
    acc_nxt = acc_q + (pp << shamt);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sb_q     <= 1'b0;
      upper_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else if (kill_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            a_q     <= {signed_a_i & op_a_i[XLEN-1], op_a_i};
            b_q     <= op_b_i;
            sb_q    <= signed_b_i;
            upper_q <= upper_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            if (op_a_i == '0 || op_b_i == '0) begin
              state_q  <= StDone;
              valid_q  <= 1'b1;
              result_q <= '0;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          acc_q <= acc_nxt;
          b_q   <= b_q >> DIGIT_W;
          if (is_last) begin
            state_q  <= StDone;
            valid_q  <= 1'b1;
            result_q <= upper_q ? acc_nxt[PW-1:XLEN] : acc_nxt[XLEN-1:0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          if (ready_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_iter_radix.sv
// Bench for mul_iter_radix: four instances (DIGIT_W 1/4/8/32) driven in lockstep and
// compared against a full-width arithmetic product model.
module tb_mul_iter_radix;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        signed_a = 1'b0;
  logic        signed_b = 1'b0;
  logic        upper = 1'b0;
  logic        kill_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [NI-1:0] rdy;
  logic [NI-1:0] vld;
  logic [31:0]   res [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned DW = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
    mul_iter_radix #(.XLEN(32), .DIGIT_W(DW)) u_dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (rdy[g]),
      .op_a_i    (op_a),
      .op_b_i    (op_b),
      .signed_a_i(signed_a),
      .signed_b_i(signed_b),
      .upper_i   (upper),
      .kill_i    (kill_i),
      .valid_o   (vld[g]),
      .ready_i   (ready_i),
      .result_o  (res[g])
    );
  end

  function automatic int ndig(input int g);
    case (g)
      0: return 32;
      1: return 8;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb, input logic up);
    logic signed [65:0] pa;
    logic signed [65:0] pb;
    logic signed [65:0] p;
    pa = sa ? {{34{a[31]}}, a} : {34'b0, a};
    pb = sb ? {{34{b[31]}}, b} : {34'b0, b};
    p  = pa * pb;
    return up ? p[63:32] : p[31:0];
  endfunction

  // Issue one op with ready_i high; check every instance's result and latency. Ends on negedge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sa,
                       input logic sb, input logic up, input logic [31:0] exp, input string name);
    bit done [NI];
    int n;
    int exp_lat;
    n = 0;
    while (rdy != '1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy !== '1) begin
      errors++;
      $display("FAIL %s ready_o wait timeout got %b exp 1111", name, rdy);
      return;
    end
    ready_i = 1'b1;
    op_a = a; op_b = b; signed_a = sa; signed_b = sb; upper = up; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    op_a = $urandom; op_b = $urandom;
    signed_a = 1'($urandom); signed_b = 1'($urandom); upper = 1'($urandom);
    foreach (done[g]) done[g] = 1'b0;
    n = 1;
    forever begin
      for (int g = 0; g < NI; g++) begin
        if (!done[g] && vld[g]) begin
          done[g] = 1'b1;
          exp_lat = (a == 0 || b == 0) ? 1 : ndig(g) + 1;
          checks++;
          if (res[g] !== exp) begin
            errors++;
            $display("FAIL %s dut%0d result got %h exp %h", name, g, res[g], exp);
          end
          checks++;
          if (n != exp_lat) begin
            errors++;
            $display("FAIL %s dut%0d latency got %0d exp %0d", name, g, n, exp_lat);
          end
        end
      end
      if (done[0] && done[1] && done[2] && done[3]) break;
      if (n >= 60) break;
      @(negedge clk);
      n++;
    end
    for (int g = 0; g < NI; g++) begin
      if (!done[g]) begin
        checks++;
        errors++;
        $display("FAIL %s dut%0d valid_o timeout got 0 exp 1", name, g);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (rdy != '1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy !== '1) begin
      errors++;
      $display("FAIL %s idle wait got %b exp 1111", name, rdy);
    end
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      checks += 3;
      if (rdy[g] !== 1'b1) begin
        errors++; $display("FAIL reset dut%0d ready_o got %b exp 1", g, rdy[g]);
      end
      if (vld[g] !== 1'b0) begin
        errors++; $display("FAIL reset dut%0d valid_o got %b exp 0", g, vld[g]);
      end
      if (res[g] !== 32'h0) begin
        errors++; $display("FAIL reset dut%0d result_o got %h exp 0", g, res[g]);
      end
    end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, "mulhu_ones");
    do_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000, "mulh_min");
    do_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000, "mul_min");
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, "mulhsu_ones");
    do_op(32'h00000007, 32'hFFFFFFFD, 1'b1, 1'b1, 1'b0, 32'hFFFFFFEB, "mul_7xm3");
    do_op(32'h00000000, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'h00000000, "early_a0");
    do_op(32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, "early_b0");
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int n;
    wait_idle("bp_pre");
    exp = ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1, 1'b1);
    ready_i = 1'b0;
    op_a = 32'h12345678; op_b = 32'h9ABCDEF0; signed_a = 1'b1; signed_b = 1'b1; upper = 1'b1;
    valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    n = 0;
    while (vld != '1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 3; c++) begin
      for (int g = 0; g < NI; g++) begin
        checks += 3;
        if (vld[g] !== 1'b1) begin
          errors++; $display("FAIL bp_hold dut%0d valid_o got %b exp 1", g, vld[g]);
        end
        if (rdy[g] !== 1'b0) begin
          errors++; $display("FAIL bp_hold dut%0d ready_o got %b exp 0", g, rdy[g]);
        end
        if (res[g] !== exp) begin
          errors++; $display("FAIL bp_hold dut%0d result got %h exp %h", g, res[g], exp);
        end
      end
      op_a = $urandom; op_b = $urandom | 32'h1; upper = ~upper;
      valid_i = (c != 1);
      @(negedge clk);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    checks += 2;
    if (vld !== '0) begin
      errors++; $display("FAIL bp_release valid_o got %b exp 0000", vld);
    end
    if (rdy !== '1) begin
      errors++; $display("FAIL bp_release ready_o got %b exp 1111", rdy);
    end
    do_op(32'hDEADBEEF, 32'h0BADF00D, 1'b0, 1'b1, 1'b1,
          ref_mul(32'hDEADBEEF, 32'h0BADF00D, 1'b0, 1'b1, 1'b1), "bp_next");
  endtask

  // Abort in the second CALC cycle by kill_i (use_rst=0) or by rst_i (use_rst=1).
  task automatic test_abort(input bit use_rst);
    string nm;
    bit seen;
    nm = use_rst ? "rst_mid" : "kill_mid";
    wait_idle(nm);
    ready_i = 1'b1;
    op_a = $urandom | 32'h1; op_b = $urandom | 32'h1; upper = 1'b1; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    if (use_rst) begin
      rst_i = 1'b1;
      #1;
      checks += 3;
      if (rdy !== '1) begin
        errors++; $display("FAIL %s async ready_o got %b exp 1111", nm, rdy);
      end
      if (vld !== '0) begin
        errors++; $display("FAIL %s async valid_o got %b exp 0000", nm, vld);
      end
      if (res[2] !== 32'h0) begin
        errors++; $display("FAIL %s async result got %h exp 0", nm, res[2]);
      end
      @(negedge clk);
      rst_i = 1'b0;
    end else begin
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      checks += 2;
      if (rdy !== '1) begin
        errors++; $display("FAIL %s ready_o got %b exp 1111", nm, rdy);
      end
      if (vld !== '0) begin
        errors++; $display("FAIL %s valid_o got %b exp 0000", nm, vld);
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (vld != '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL %s stale valid got 1 exp 0", nm);
    end
    do_op(32'hFFFFFFF9, 32'h00000003, 1'b1, 1'b0, 1'b0, 32'hFFFFFFEB, {nm, "_recover"});
  endtask

  task automatic test_kill_idle();
    bit seen;
    wait_idle("kill_idle");
    op_a = 32'h00001234; op_b = 32'h00005678; valid_i = 1'b1; kill_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; kill_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (vld != '0 || rdy != '1) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL kill_idle accepted got 1 exp 0");
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic        up;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: a = 32'h0;
        1: b = 32'h0;
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        4: a = 32'($urandom_range(1, 15));
        default: ;
      endcase
      sa = 1'($urandom); sb = 1'($urandom); up = 1'($urandom);
      do_op(a, b, sa, sb, up, ref_mul(a, b, sa, sb, up), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_kill_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
